audio_clk_seq: RTL and testbench

- Lock sequencer and sample-rate strobe generator placed directly downstream of the audio PLL.
- Runs on the PLL's 48 MHz output clock and consumes the PLL's asynchronous locked signal.
- Holds the audio core in reset until lock has been stable for a programmable interval.
- Emits a single-cycle 48 kHz sample strobe; on lock loss it re-asserts core reset and re-sequences.

---
 rtl/audio_clk_pkg.sv | 21 ++
 rtl/audio_clk_seq_sync.sv | 26 ++
 rtl/audio_clk_seq.sv | 123 ++++++++++++
 tb/tb_audio_clk_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_clk_pkg.sv
// Shared types and default constants for the audio PLL lock sequencer.
// Holds the sequencer state encoding and a counter-width helper.
package audio_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam int AUDIO_SAMPLE_DIV  = 1000;
  localparam int AUDIO_LOCK_STABLE = 4096;
  localparam int AUDIO_HOLD        = 256;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_clk_seq_sync.sv
// sync_bit: SYNC_STAGES-deep flop chain bringing one async bit into clk.
// Ports: clk, rst_n (async, clears chain), d (async in), q (synchronized).
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/audio_clk_seq.sv
// audio_clk_seq: holds the audio core in reset until the PLL lock has been
// stable, then emits a one-cycle strobe every SAMPLE_DIV clocks.
// Ports: clk, rst_n (async), pll_locked (async) in; core_rst_n, sample_stb,
// running, lock_loss_cnt[7:0] out, all registered.
// AUDIO_CLK_SEQ_LOSS_CNT_EN: enables the saturating lock-loss counter;
// otherwise lock_loss_cnt is tied to zero.
module audio_clk_seq
  import audio_clk_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = AUDIO_LOCK_STABLE,
  parameter int HOLD_CYCLES        = AUDIO_HOLD,
  parameter int SAMPLE_DIV         = AUDIO_SAMPLE_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       core_rst_n,
  output logic       sample_stb,
  output logic       running,
  output logic [7:0] lock_loss_cnt
);

  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int DW = cnt_w(SAMPLE_DIV);

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);

  logic locked_s;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  state_e        state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] div_q, div_d;
  logic          run_q, run_d;
  logic          stb_q, stb_d;

  // Counters idle at zero outside their own state, so each
  // state always starts counting from zero.
  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    hold_d   = '0;
    div_d    = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s)                  state_d  = WAIT_LOCK;
        else if (stable_q == STABLE_LAST) state_d  = RUN;
        else                            stable_d = stable_q + 1'b1;
      end
      RUN: begin
        if (!locked_s)              state_d = HOLD;
        else if (div_q != DIV_LAST) div_d   = div_q + 1'b1;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Outputs follow next state so they line up with RUN cycles;
    // a strobe due on the lock-loss cycle is dropped here.
    run_d = (state_d == RUN);
    stb_d = run_d && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      stable_q <= '0;
      hold_q   <= '0;
      div_q    <= '0;
      run_q    <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      run_q    <= run_d;
      stb_q    <= stb_d;
    end
  end

  assign core_rst_n = run_q;
  assign running    = run_q;
  assign sample_stb = stb_q;

`ifdef AUDIO_CLK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == RUN && !locked_s && loss_q != 8'hFF)
      loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_q <= 8'd0;
    else        loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_audio_clk_seq.sv
// Scoreboard bench for audio_clk_seq: small-parameter and default instances.
// Stimulus queues expected output events; monitors pop and compare them.
module tb_audio_clk_seq;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_STB  = 2;

`ifdef AUDIO_CLK_SEQ_LOSS_CNT_EN
  localparam int EXP_L1  = 1;
  localparam int EXP_L3  = 3;
  localparam int EXP_SAT = 255;
`else
  localparam int EXP_L1  = 0;
  localparam int EXP_L3  = 0;
  localparam int EXP_SAT = 0;
`endif

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll1 = 1'b0;
  logic       pll2 = 1'b0;
  logic       core1, stb1, run1;
  logic       core2, stb2, run2;
  logic [7:0] loss1, loss2;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t q1[$];
  ev_t q2[$];
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_clk_seq #(
    .SYNC_STAGES(2),
    .LOCK_STABLE_CYCLES(8),
    .HOLD_CYCLES(4),
    .SAMPLE_DIV(5)
  ) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll1),
    .core_rst_n   (core1),
    .sample_stb   (stb1),
    .running      (run1),
    .lock_loss_cnt(loss1)
  );

  audio_clk_seq dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll2),
    .core_rst_n   (core2),
    .sample_stb   (stb2),
    .running      (run2),
    .lock_loss_cnt(loss2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push1(input int k, input int c);
    q1.push_back('{kind: k, cyc: c});
  endtask

  task automatic push2(input int k, input int c);
    q2.push_back('{kind: k, cyc: c});
  endtask

  task automatic pop1(input int k, input int c, input logic rn);
    ev_t e;
    n_tests++;
    if (q1.size() == 0) begin
      n_fail++;
      $display("FAIL dut1 unexpected event: kind %0d at cyc %0d", k, c);
    end else begin
      e = q1.pop_front();
      if (e.kind != k || e.cyc != c || rn != (k != K_FALL)) begin
        n_fail++;
        $display("FAIL dut1 event: got kind %0d cyc %0d run %0b want kind %0d cyc %0d",
                 k, c, rn, e.kind, e.cyc);
      end
    end
  endtask

  task automatic pop2(input int k, input int c, input logic rn);
    ev_t e;
    n_tests++;
    if (q2.size() == 0) begin
      n_fail++;
      $display("FAIL dut2 unexpected event: kind %0d at cyc %0d", k, c);
    end else begin
      e = q2.pop_front();
      if (e.kind != k || e.cyc != c || rn != (k != K_FALL)) begin
        n_fail++;
        $display("FAIL dut2 event: got kind %0d cyc %0d run %0b want kind %0d cyc %0d",
                 k, c, rn, e.kind, e.cyc);
      end
    end
  endtask

  // Monitors: turn output activity into events and score them.
  always @(negedge clk) begin
    if (core1 && !prev1) pop1(K_RISE, cyc, run1);
    if (!core1 && prev1) pop1(K_FALL, cyc, run1);
    if (stb1)            pop1(K_STB, cyc, run1 & core1);
    prev1 <= core1;
  end

  always @(negedge clk) begin
    if (core2 && !prev2) pop2(K_RISE, cyc, run2);
    if (!core2 && prev2) pop2(K_FALL, cyc, run2);
    if (stb2)            pop2(K_STB, cyc, run2 & core2);
    prev2 <= core2;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    wait_cyc(3);
    chk("reset core_rst_n", int'(core1), 0);
    chk("reset sample_stb", int'(stb1), 0);
    chk("reset running", int'(run1), 0);
    chk("reset lock_loss_cnt", int'(loss1), 0);
    chk("reset dut2 core_rst_n", int'(core2), 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Clean lock: rise after 11 edges, strobes at RUN 4, 9, 14.
    r = cyc;
    push1(K_RISE, r + 11);
    push1(K_STB, r + 15);
    push1(K_STB, r + 20);
    push1(K_STB, r + 25);
    push1(K_FALL, r + 30);
    pll1 = 1'b1;
    wait_cyc(29);
    // Async reset during the RUN-19 strobe cycle.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async core_rst_n", int'(core1), 0);
    chk("async sample_stb", int'(stb1), 0);
    chk("async running", int'(run1), 0);
    chk("async lock_loss_cnt", int'(loss1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from WAIT_LOCK, then lose lock at RUN cycle 3.
    r = cyc;
    push1(K_RISE, r + 11);
    push1(K_STB, r + 15);
    push1(K_FALL, r + 17);
    push1(K_RISE, r + 30);
    push1(K_FALL, r + 33);
    wait_cyc(14);
    pll1 = 1'b0;
    wait_cyc(3);
    // Relock during HOLD; HOLD must still run its full 4 cycles.
    pll1 = 1'b1;
    wait_cyc(1);
    chk("loss cnt after 1st loss", int'(loss1), EXP_L1);
    wait_cyc(12);
    pll1 = 1'b0;
    wait_cyc(8);

    // One-cycle glitch at STABLE count 5 restarts the sequence.
    r = cyc;
    push1(K_RISE, r + 20);
    push1(K_FALL, r + 23);
    pll1 = 1'b1;
    wait_cyc(8);
    pll1 = 1'b0;
    wait_cyc(1);
    pll1 = 1'b1;
    wait_cyc(11);
    pll1 = 1'b0;
    wait_cyc(8);
    chk("loss cnt after glitch run", int'(loss1), EXP_L3);

    // Saturation: 257 more losses, 260 total.
    for (int i = 0; i < 257; i++) begin
      r = cyc;
      push1(K_RISE, r + 11);
      push1(K_FALL, r + 14);
      pll1 = 1'b1;
      wait_cyc(11);
      pll1 = 1'b0;
      wait_cyc(7);
    end
    chk("loss cnt saturated", int'(loss1), EXP_SAT);
    chk("dut2 loss cnt idle", int'(loss2), 0);

    // Default parameters: ten strobes 1000 cycles apart.
    r = cyc;
    push2(K_RISE, r + 4099);
    for (int k = 0; k < 10; k++) push2(K_STB, r + 4099 + 999 + 1000 * k);
    pll2 = 1'b1;
    wait_cyc(4099 + 999 + 9000 + 5);

    chk("dut1 events left", q1.size(), 0);
    chk("dut2 events left", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
